// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES key schedule constants, state type and half-rotation helpers
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam int HALF_W     = 28;
    localparam int SUBKEY_W   = 48;

    // Per-round left-rotation amounts; entry r-1 holds SHIFT for round r.
    localparam logic [1:0] SHIFT_TBL [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_e;

    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] n);
        return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                           : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                           : {x[0], x[HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/des_key_schedule_ctrl_if.sv
// rtl/des_key_schedule_ctrl_if.sv - key input and subkey output handshakes of the key scheduler
interface des_key_schedule_ctrl_if;
    import des_pkg::*;

    logic [63:0]         key_in;
    logic                decrypt;
    logic                key_valid;
    logic                key_ready;
    logic [SUBKEY_W-1:0] subkey;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [3:0]          round_idx;
    logic                subkey_last;

    modport master (
        output key_in, decrypt, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_valid, round_idx, subkey_last
    );

    modport slave (
        input  key_in, decrypt, key_valid, subkey_ready,
        output key_ready, subkey, subkey_valid, round_idx, subkey_last
    );

endinterface

// File: rtl/des_key_schedule_ctrl_pc2.sv
// rtl/des_key_schedule_ctrl_pc2.sv - DES PC-2, 56-bit C/D to 48-bit round subkey
module permuted_choice_2
    import des_pkg::*;
(
    input  logic [55:0]         cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    localparam int PC2_TBL [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign subkey_o[SUBKEY_W-1-i] = cd_i[56-PC2_TBL[i]];
    end

    logic unused_dropped;
    assign unused_dropped = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                              cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/permuted_choice_1.sv
// rtl/permuted_choice_1.sv - DES PC-1, 64-bit key to 56-bit C/D; parity bits dropped
module permuted_choice_1 (
    input  logic [63:0] key_i,
    output logic [55:0] cd_o
);

    // FIPS numbering: bit 1 is the MSB of the key.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign cd_o[55-i] = key_i[64-PC1_TBL[i]];
    end

    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

// File: rtl/des_key_schedule_ctrl.sv
// rtl/des_key_schedule_ctrl.sv - sequences the 16 DES subkeys in encrypt or decrypt order
module des_key_schedule_ctrl
    import des_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    des_key_schedule_ctrl_if.slave  bus
);

    logic [55:0]         pc1_w;
    logic [SUBKEY_W-1:0] pc2_w;

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d;

    permuted_choice_1 u_pc1 (
        .key_i (bus.key_in),
        .cd_o  (pc1_w)
    );

    permuted_choice_2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (pc2_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = GEN;
                    mode_d  = bus.decrypt;
                    round_d = '0;
                    // Decrypt starts at C16/D16, which equals C0/D0 since the shifts total 28.
                    if (bus.decrypt) begin
                        c_d = pc1_w[55:28];
                        d_d = pc1_w[27:0];
                    end else begin
                        c_d = rotl_half(pc1_w[55:28], SHIFT_TBL[0]);
                        d_d = rotl_half(pc1_w[27:0],  SHIFT_TBL[0]);
                    end
                end
            end
            GEN: begin
                if (bus.subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + 4'd1;
                        if (mode_q) begin
                            c_d = rotr_half(c_q, SHIFT_TBL[4'd15 - round_q]);
                            d_d = rotr_half(d_q, SHIFT_TBL[4'd15 - round_q]);
                        end else begin
                            c_d = rotl_half(c_q, SHIFT_TBL[round_q + 4'd1]);
                            d_d = rotl_half(d_q, SHIFT_TBL[round_q + 4'd1]);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.key_ready    = (state_q == IDLE);
    assign bus.subkey_valid = (state_q == GEN);
    assign bus.subkey_last  = (state_q == GEN) && (round_q == 4'd15);
    assign bus.round_idx    = round_q;
    assign bus.subkey       = pc2_w;

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// tb/tb_des_key_schedule_ctrl.sv - self-checking bench for des_key_schedule_ctrl
module tb_des_key_schedule_ctrl;

    logic clk;
    logic rst;

    des_key_schedule_ctrl_if bus ();

    des_key_schedule_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs;
    int checks;

    typedef struct {
        logic [47:0] k;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    logic [47:0] seen_q [$];
    logic [47:0] mk [16];
    logic [47:0] t1_seq [16];

    int TB_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                        10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                        14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int TB_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                        16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                        44,49,39,56,34,53, 46,42,50,36,29,32};
    int TB_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [27:0] rot_by(input logic [27:0] x, input int n);
        logic [55:0] xx;
        xx = {x, x};
        return xx[55-n -: 28];
    endfunction

    // Kn is PC2 of the PC-1 halves rotated by the cumulative shift up to round n.
    task automatic compute_model(input logic [63:0] key);
        logic [55:0] cd;
        logic [55:0] r;
        int tot;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
        tot = 0;
        for (int n = 0; n < 16; n++) begin
            tot += TB_SHIFT[n];
            r = {rot_by(cd[55:28], tot), rot_by(cd[27:0], tot)};
            for (int j = 0; j < 48; j++) mk[n][47-j] = r[56-TB_PC2[j]];
        end
    endtask

    task automatic push_model(input logic [63:0] key, input logic dec);
        exp_t e;
        compute_model(key);
        for (int p = 0; p < 16; p++) begin
            e.k    = dec ? mk[15-p] : mk[p];
            e.idx  = 4'(p);
            e.last = (p == 15);
            exp_q.push_back(e);
        end
    endtask

    exp_t ce;
    always @(negedge clk) begin
        if (!rst && bus.subkey_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_subkey_valid", 64'(bus.subkey_valid), 64'd0);
            end else begin
                ce = exp_q[0];
                chk("subkey", 64'(bus.subkey), 64'(ce.k));
                chk("round_idx", 64'(bus.round_idx), 64'(ce.idx));
                chk("subkey_last", 64'(bus.subkey_last), 64'(ce.last));
                chk("key_ready_in_gen", 64'(bus.key_ready), 64'd0);
                if (bus.subkey_ready) begin
                    void'(exp_q.pop_front());
                    seen_q.push_back(bus.subkey);
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.key_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.key_ready) fail_now("wait_key_ready");
    endtask

    task automatic run_key(input logic [63:0] key, input logic dec,
                           input bit stall, input bit pulse);
        int n;
        wait_ready();
        bus.key_in       = key;
        bus.decrypt      = dec;
        bus.key_valid    = 1'b1;
        bus.subkey_ready = 1'b1;
        @(posedge clk); #1;
        push_model(key, dec);
        bus.key_valid = 1'b0;
        bus.key_in    = 64'($urandom) << 32 | 64'($urandom);
        bus.decrypt   = ~dec;
        chk("first_valid_latency", 64'(bus.subkey_valid), 64'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            bus.subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse && n == 5) begin
                bus.key_valid = 1'b1;
                chk("key_ready_mid_gen", 64'(bus.key_ready), 64'd0);
            end else begin
                bus.key_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_sequence");
        bus.key_valid    = 1'b0;
        bus.subkey_ready = 1'b1;
    endtask

    initial begin
        int n;
        errs   = 0;
        checks = 0;
        rst              = 1'b1;
        bus.key_in       = '0;
        bus.decrypt      = 1'b0;
        bus.key_valid    = 1'b0;
        bus.subkey_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst_subkey_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_subkey_last", 64'(bus.subkey_last), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);
        chk("rst_round_idx", 64'(bus.round_idx), 64'd0);
        rst = 1'b0;

        // Pin the model to the published FIPS example subkeys.
        compute_model(64'h133457799BBCDFF1);
        chk("model_k1", 64'(mk[0]), 64'h1B02EFFC7072);
        chk("model_k16", 64'(mk[15]), 64'hCB3D8B0E17F5);
        compute_model(64'hFFFFFFFFFFFFFFFF);
        chk("model_ones_k8", 64'(mk[7]), 64'hFFFFFFFFFFFF);

        // 1: encrypt order
        seen_q.delete();
        run_key(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0);
        chk("t1_count", 64'(seen_q.size()), 64'd16);
        if (seen_q.size() == 16) begin
            chk("t1_first", 64'(seen_q[0]), 64'h1B02EFFC7072);
            chk("t1_last", 64'(seen_q[15]), 64'hCB3D8B0E17F5);
            for (int i = 0; i < 16; i++) t1_seq[i] = seen_q[i];
        end

        // 2: decrypt order reverses test 1
        seen_q.delete();
        run_key(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0);
        chk("t2_count", 64'(seen_q.size()), 64'd16);
        if (seen_q.size() == 16) begin
            chk("t2_first", 64'(seen_q[0]), 64'hCB3D8B0E17F5);
            for (int i = 0; i < 16; i++) chk("t2_reverse", 64'(seen_q[i]), 64'(t1_seq[15-i]));
        end

        // 3: degenerate keys
        seen_q.delete();
        run_key(64'h0000000000000000, 1'b0, 1'b0, 1'b0);
        run_key(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
        run_key(64'h0101010101010101, 1'b0, 1'b0, 1'b0);
        chk("t3_count", 64'(seen_q.size()), 64'd48);
        if (seen_q.size() == 48) begin
            chk("t3_zero", 64'(seen_q[3]), 64'd0);
            chk("t3_ones", 64'(seen_q[20]), 64'hFFFFFFFFFFFF);
            chk("t3_parity_flip", 64'(seen_q[40]), 64'd0);
        end

        // 4: random backpressure with a stray key_valid mid-sequence
        seen_q.delete();
        run_key(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b1);
        chk("t4_count", 64'(seen_q.size()), 64'd16);
        if (seen_q.size() == 16)
            for (int i = 0; i < 16; i++) chk("t4_same_as_t1", 64'(seen_q[i]), 64'(t1_seq[i]));

        // 5: reset in the middle of a schedule
        wait_ready();
        bus.key_in    = 64'h0E329232EA6D0D73;
        bus.decrypt   = 1'b0;
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        push_model(64'h0E329232EA6D0D73, 1'b0);
        bus.key_valid = 1'b0;
        n = 0;
        while (bus.round_idx != 4'd7 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.round_idx != 4'd7) fail_now("reach_round7");
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("t5_valid_after_rst", 64'(bus.subkey_valid), 64'd0);
        chk("t5_ready_after_rst", 64'(bus.key_ready), 64'd1);
        chk("t5_idx_after_rst", 64'(bus.round_idx), 64'd0);
        rst = 1'b0;
        seen_q.delete();
        run_key(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0);
        if (seen_q.size() > 0) chk("t5_restart_k1", 64'(seen_q[0]), 64'h1B02EFFC7072);
        else fail_now("t5_restart");

        // 6: back-to-back keys
        wait_ready();
        bus.key_in       = 64'h133457799BBCDFF1;
        bus.decrypt      = 1'b0;
        bus.key_valid    = 1'b1;
        bus.subkey_ready = 1'b1;
        @(posedge clk); #1;
        push_model(64'h133457799BBCDFF1, 1'b0);
        bus.key_in  = 64'h0E329232EA6D0D73;
        bus.decrypt = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t6_key_ready_low", 64'(bus.key_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("t6_key_ready_high", 64'(bus.key_ready), 64'd1);
        chk("t6_gap_valid", 64'(bus.subkey_valid), 64'd0);
        chk("t6_first_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        push_model(64'h0E329232EA6D0D73, 1'b1);
        bus.key_valid = 1'b0;
        chk("t6_second_start", 64'(bus.subkey_valid), 64'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now("t6_drain");
        chk("t6_idle_after", 64'(bus.key_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
